// File: rtl/tile_render_pipe.sv
// Tile-map pixel renderer: screen coordinate -> board -> sprite -> colour RAM, with frame-synced X/Y scroll and border.
// Latency 5 cycles, one pixel per cycle; no backpressure, bubbles flow through. Optional flip via TILE_RENDER_PIPE_FLIP_EN.
// Board data is sampled two edges after its address, sprite and colour data one edge after theirs.
module tile_render_pipe #(
  parameter int          TILE_LOG2  = 4,
  parameter int          SCALE_LOG2 = 1,
  parameter int          BOARD_COLS = 40,
  parameter int          BOARD_ROWS = 30,
  parameter int          TILE_ID_W  = 5,
  parameter int          PIX_ID_W   = 6,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pix_valid,
  input  logic [11:0]          display_col,
  input  logic [10:0]          display_row,
  input  logic                 scroll_we,
  input  logic [11:0]          scroll_x,
  input  logic [10:0]          scroll_y,
  output logic                 scroll_err,
  output logic [10:0]          board_rdaddress,
`ifdef TILE_RENDER_PIPE_FLIP_EN
  input  logic [TILE_ID_W+1:0] board_q,
`else
  input  logic [TILE_ID_W-1:0] board_q,
`endif
  output logic [12:0]          sprite_rdaddress,
  input  logic [PIX_ID_W-1:0]  sprite_q,
  output logic [PIX_ID_W-1:0]  color_rdaddress,
  input  logic [23:0]          color_q,
  output logic [23:0]          color,
  output logic                 color_valid
);

  localparam int         SH      = TILE_LOG2 + SCALE_LOG2;
  localparam logic [12:0] WORLD_W = 13'(BOARD_COLS << SH);
  localparam logic [11:0] WORLD_H = 12'(BOARD_ROWS << SH);

  logic [11:0] shadow_x, active_x, sx_eff;
  logic [10:0] shadow_y, active_y, sy_eff;
  logic        scroll_ok, frame_start, in_board;
  logic [12:0] wx_sum, wx;
  logic [11:0] wy_sum, wy;
  logic [TILE_LOG2-1:0] tx_c, ty_c;

  logic                 vld1, vld2, vld3, vld4;
  logic                 brd1, brd2, brd3, brd4;
  logic [TILE_LOG2-1:0] tx1, ty1, tx2, ty2;

  logic [TILE_ID_W-1:0] tile_id;
  logic [TILE_LOG2-1:0] tx_s3, ty_s3;

  // Coordinate stage: scroll selection, world wrap, border detect.
  always_comb begin
    scroll_ok   = ({1'b0, scroll_x} < WORLD_W) && ({1'b0, scroll_y} < WORLD_H);
    frame_start = pix_valid && (display_col == '0) && (display_row == '0);
    sx_eff      = active_x;
    sy_eff      = active_y;
    if (frame_start) begin
      // A write landing on the frame-start pixel already applies to this frame.
      if (scroll_we && scroll_ok) begin
        sx_eff = scroll_x;
        sy_eff = scroll_y;
      end else begin
        sx_eff = shadow_x;
        sy_eff = shadow_y;
      end
    end
    wx_sum   = {1'b0, display_col} + {1'b0, sx_eff};
    wy_sum   = {1'b0, display_row} + {1'b0, sy_eff};
    wx       = (wx_sum >= WORLD_W) ? wx_sum - WORLD_W : wx_sum;
    wy       = (wy_sum >= WORLD_H) ? wy_sum - WORLD_H : wy_sum;
    in_board = ({1'b0, display_col} < WORLD_W) && ({1'b0, display_row} < WORLD_H);
    tx_c     = wx[SCALE_LOG2 +: TILE_LOG2];
    ty_c     = wy[SCALE_LOG2 +: TILE_LOG2];
  end

  // Sprite stage: tile id from board RAM, optional per-tile mirroring.
  always_comb begin
    tile_id = board_q[TILE_ID_W-1:0];
    tx_s3   = tx2;
    ty_s3   = ty2;
`ifdef TILE_RENDER_PIPE_FLIP_EN
    if (board_q[TILE_ID_W])   tx_s3 = ~tx2;
    if (board_q[TILE_ID_W+1]) ty_s3 = ~ty2;
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_x   <= '0;
      shadow_y   <= '0;
      active_x   <= '0;
      active_y   <= '0;
      scroll_err <= 1'b0;
    end else begin
      scroll_err <= scroll_we && !scroll_ok;
      if (scroll_we && scroll_ok) begin
        shadow_x <= scroll_x;
        shadow_y <= scroll_y;
      end
      if (frame_start) begin
        active_x <= sx_eff;
        active_y <= sy_eff;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld1             <= 1'b0;
      vld2             <= 1'b0;
      vld3             <= 1'b0;
      vld4             <= 1'b0;
      brd1             <= 1'b0;
      brd2             <= 1'b0;
      brd3             <= 1'b0;
      brd4             <= 1'b0;
      tx1              <= '0;
      ty1              <= '0;
      tx2              <= '0;
      ty2              <= '0;
      board_rdaddress  <= '0;
      sprite_rdaddress <= '0;
      color_rdaddress  <= '0;
      color            <= '0;
      color_valid      <= 1'b0;
    end else begin
      // Edge 1: board fetch
      vld1            <= pix_valid;
      brd1            <= !in_board;
      tx1             <= tx_c;
      ty1             <= ty_c;
      board_rdaddress <= 11'(32'(wy >> SH) * 32'(BOARD_COLS) + 32'(wx >> SH));
      // Edge 2: wait for board data
      vld2            <= vld1;
      brd2            <= brd1;
      tx2             <= tx1;
      ty2             <= ty1;
      // Edge 3: sprite fetch
      vld3             <= vld2;
      brd3             <= brd2;
      sprite_rdaddress <= 13'((32'(tile_id) << (2 * TILE_LOG2)) |
                              (32'(ty_s3) << TILE_LOG2) | 32'(tx_s3));
      // Edge 4: palette fetch
      vld4            <= vld3;
      brd4            <= brd3;
      color_rdaddress <= sprite_q;
      // Edge 5: colour out; held through bubbles
      color_valid <= vld4;
      if (vld4) color <= brd4 ? BORDER_RGB : color_q;
    end
  end

endmodule

// File: tb/tb_tile_render_pipe.sv
// Bench for tile_render_pipe: RAM models, scroll/pixel reference model, directed and random scenarios.
module tb_tile_render_pipe;
  localparam int WORLD_W = 1280;
  localparam int WORLD_H = 960;
`ifdef TILE_RENDER_PIPE_FLIP_EN
  localparam int BDW = 7;
`else
  localparam int BDW = 5;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          pix_valid = 1'b0;
  logic [11:0]   display_col = '0;
  logic [10:0]   display_row = '0;
  logic          scroll_we = 1'b0;
  logic [11:0]   scroll_x = '0;
  logic [10:0]   scroll_y = '0;
  logic          scroll_err;
  logic [10:0]   board_rdaddress;
  logic [BDW-1:0] board_q = '0;
  logic [12:0]   sprite_rdaddress;
  logic [5:0]    sprite_q;
  logic [5:0]    color_rdaddress;
  logic [23:0]   color_q;
  logic [23:0]   color;
  logic          color_valid;

  logic [BDW-1:0] board_mem  [0:2047];
  logic [5:0]     sprite_mem [0:8191];
  logic [23:0]    color_mem  [0:63];

  tile_render_pipe dut (
    .clock(clock), .reset(reset), .pix_valid(pix_valid),
    .display_col(display_col), .display_row(display_row),
    .scroll_we(scroll_we), .scroll_x(scroll_x), .scroll_y(scroll_y), .scroll_err(scroll_err),
    .board_rdaddress(board_rdaddress), .board_q(board_q),
    .sprite_rdaddress(sprite_rdaddress), .sprite_q(sprite_q),
    .color_rdaddress(color_rdaddress), .color_q(color_q),
    .color(color), .color_valid(color_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) board_q <= board_mem[board_rdaddress];
  assign sprite_q = sprite_mem[sprite_rdaddress];
  assign color_q  = color_mem[color_rdaddress];

  typedef struct { bit v; logic [23:0] c; } pend_t;
  pend_t       pend[$];
  int          m_shx, m_shy, m_acx, m_acy, m_baddr;
  bit          m_vld, m_err;
  logic [23:0] m_color;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [23:0] ref_color(int col, int row, int sx, int sy);
    int wx, wy, tile, tx, ty;
    logic [BDW-1:0] e;
    if (col >= WORLD_W || row >= WORLD_H) return 24'h000000;
    wx = (col + sx) % WORLD_W;
    wy = (row + sy) % WORLD_H;
    e = board_mem[(wy / 32) * 40 + wx / 32];
    tile = int'(e[4:0]);
    tx = (wx / 2) % 16;
    ty = (wy / 2) % 16;
`ifdef TILE_RENDER_PIPE_FLIP_EN
    if (e[5]) tx = 15 - tx;
    if (e[6]) ty = 15 - ty;
`endif
    return color_mem[sprite_mem[tile * 256 + ty * 16 + tx]];
  endfunction

  function automatic int ref_baddr(int col, int row, int sx, int sy);
    return (((row + sy) % WORLD_H) / 32) * 40 + ((col + sx) % WORLD_W) / 32;
  endfunction

  task automatic model_clear();
    pend.delete();
    m_vld = 0; m_err = 0; m_color = '0;
    m_shx = 0; m_shy = 0; m_acx = 0; m_acy = 0; m_baddr = 0;
  endtask

  task automatic step(input bit v, input int c, input int r, input bit we, input int sx, input int sy);
    bit ok, fs;
    pend_t pe;
    pix_valid = v; display_col = c[11:0]; display_row = r[10:0];
    scroll_we = we; scroll_x = sx[11:0]; scroll_y = sy[10:0];
    @(posedge clock);
    ok = (sx < WORLD_W) && (sy < WORLD_H);
    fs = v && c == 0 && r == 0;
    if (fs) begin
      if (we && ok) begin m_acx = sx; m_acy = sy; end
      else begin m_acx = m_shx; m_acy = m_shy; end
    end
    if (we && ok) begin m_shx = sx; m_shy = sy; end
    m_err = we && !ok;
    m_baddr = ref_baddr(c, r, m_acx, m_acy);
    if (pend.size() == 4) begin
      pe = pend.pop_front();
      m_vld = pe.v;
      if (pe.v) m_color = pe.c;
    end else m_vld = 0;
    pe.v = v;
    pe.c = ref_color(c, r, m_acx, m_acy);
    pend.push_back(pe);
    #1;
    pix_valid = 1'b0; scroll_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    n_checks += 6;
    if (board_rdaddress !== 11'd0) begin n_fail++; $display("FAIL reset_board_addr: got %0d want 0", board_rdaddress); end
    if (sprite_rdaddress !== 13'd0) begin n_fail++; $display("FAIL reset_sprite_addr: got %0d want 0", sprite_rdaddress); end
    if (color_rdaddress !== 6'd0) begin n_fail++; $display("FAIL reset_color_addr: got %0d want 0", color_rdaddress); end
    if (color !== 24'h0) begin n_fail++; $display("FAIL reset_color: got %h want 0", color); end
    if (color_valid !== 1'b0) begin n_fail++; $display("FAIL reset_color_valid: got %b want 0", color_valid); end
    if (scroll_err !== 1'b0) begin n_fail++; $display("FAIL reset_scroll_err: got %b want 0", scroll_err); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
  endtask

  task automatic test_basic_pixel();
    board_mem[81] = BDW'(3);
    step(1, 37, 70, 0, 0, 0);
    n_checks++;
    if (board_rdaddress !== 11'd81) begin n_fail++; $display("FAIL basic_board_addr: got %0d want 81", board_rdaddress); end
    for (int i = 2; i <= 6; i++) begin
      step(0, 0, 5, 0, 0, 0);
      if (i == 3) begin
        n_checks++;
        if (sprite_rdaddress !== 13'd818) begin n_fail++; $display("FAIL basic_sprite_addr: got %0d want 818", sprite_rdaddress); end
      end
      if (i == 5) begin
        n_checks++;
        if (color_valid !== 1'b1 || color !== color_mem[sprite_mem[818]]) begin
          n_fail++; $display("FAIL basic_color: got v=%b %h want v=1 %h", color_valid, color, color_mem[sprite_mem[818]]);
        end
      end
      n_checks++;
      if (color_valid !== m_vld || color !== m_color) begin
        n_fail++; $display("FAIL basic_pipe step %0d: got v=%b %h want v=%b %h", i, color_valid, color, m_vld, m_color);
      end
    end
  endtask

  task automatic test_scroll_update();
    int tc[7] = '{5, 40, 0, 40, 20, 0, 100};
    int tr[7] = '{3, 0, 0, 0, 0, 0, 100};
    bit tw[7] = '{1, 0, 0, 0, 0, 1, 0};
    int tx[7] = '{1270, 0, 0, 0, 0, 64, 0};
    int ty[7] = '{0, 0, 0, 0, 0, 32, 0};
    int eb[7] = '{0, 1, 39, 0, 0, 42, 165};
    for (int i = 0; i < 7; i++) begin
      step(1, tc[i], tr[i], tw[i], tx[i], ty[i]);
      n_checks += 2;
      if (board_rdaddress !== 11'(eb[i])) begin n_fail++; $display("FAIL scroll_board_addr %0d: got %0d want %0d", i, board_rdaddress, eb[i]); end
      if (color_valid !== m_vld || color !== m_color) begin
        n_fail++; $display("FAIL scroll_pipe %0d: got v=%b %h want v=%b %h", i, color_valid, color, m_vld, m_color);
      end
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 7, 7, 0, 0, 0);
      n_checks++;
      if (color_valid !== m_vld || color !== m_color) begin
        n_fail++; $display("FAIL scroll_drain %0d: got v=%b %h want v=%b %h", i, color_valid, color, m_vld, m_color);
      end
    end
  endtask

  task automatic test_scroll_err();
    bit tv[6] = '{0, 0, 0, 1, 0, 1};
    bit tw[6] = '{1, 0, 1, 0, 1, 0};
    int tx[6] = '{100, 0, 1280, 0, 1279, 0};
    int ty[6] = '{960, 0, 0, 0, 959, 0};
    bit ee[6] = '{1, 0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(tv[i], 0, 0, tw[i], tx[i], ty[i]);
      n_checks++;
      if (scroll_err !== ee[i]) begin n_fail++; $display("FAIL scroll_err %0d: got %b want %b", i, scroll_err, ee[i]); end
      if (i == 3) begin
        n_checks++;
        if (board_rdaddress !== 11'd42) begin n_fail++; $display("FAIL err_shadow_kept: got %0d want 42", board_rdaddress); end
      end
      if (i == 5) begin
        n_checks++;
        if (board_rdaddress !== 11'd1199) begin n_fail++; $display("FAIL edge_scroll_addr: got %0d want 1199", board_rdaddress); end
      end
    end
  endtask

  task automatic test_border();
    int tc[4] = '{1280, 0, 1279, 4095};
    int tr[4] = '{0, 960, 959, 2047};
    for (int i = 0; i < 9; i++) begin
      if (i < 4) step(1, tc[i], tr[i], 0, 0, 0);
      else step(0, 3, 3, 0, 0, 0);
      if (i == 4) begin
        n_checks++;
        if (color_valid !== 1'b1 || color !== 24'h000000) begin
          n_fail++; $display("FAIL border_color: got v=%b %h want v=1 000000", color_valid, color);
        end
      end
      n_checks++;
      if (color_valid !== m_vld || color !== m_color) begin
        n_fail++; $display("FAIL border_pipe %0d: got v=%b %h want v=%b %h", i, color_valid, color, m_vld, m_color);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 400; i++) begin
      bit v, we;
      int c, r;
      v = ($urandom_range(0, 3) != 0);
      c = $urandom_range(0, 1400);
      r = $urandom_range(0, 1050);
      if ($urandom_range(0, 24) == 0) begin v = 1; c = 0; r = 0; end
      we = ($urandom_range(0, 9) == 0);
      step(v, c, r, we, $urandom_range(0, 1400), $urandom_range(0, 1050));
      n_checks++;
      if (color_valid !== m_vld || color !== m_color || scroll_err !== m_err) begin
        n_fail++;
        $display("FAIL random %0d: got v=%b %h err=%b want v=%b %h err=%b", i, color_valid, color, scroll_err, m_vld, m_color, m_err);
      end
    end
  endtask

  task automatic test_reset_midstream();
    bit pat[6] = '{1, 0, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++) begin
      step(pat[i], $urandom_range(1, 1279), $urandom_range(1, 959), 0, 0, 0);
      n_checks++;
      if (color_valid !== m_vld || color !== m_color) begin
        n_fail++; $display("FAIL mid_pipe %0d: got v=%b %h want v=%b %h", i, color_valid, color, m_vld, m_color);
      end
    end
    n_checks++;
    if (color_valid !== 1'b0) begin n_fail++; $display("FAIL mid_bubble: got %b want 0", color_valid); end
    reset = 1'b1;
    #2;
    n_checks++;
    if (color_valid !== 1'b0 || color !== 24'h0 || board_rdaddress !== 11'd0 ||
        sprite_rdaddress !== 13'd0 || color_rdaddress !== 6'd0 || scroll_err !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got v=%b c=%h b=%0d s=%0d p=%0d e=%b want all 0",
                         color_valid, color, board_rdaddress, sprite_rdaddress, color_rdaddress, scroll_err);
    end
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_clear();
    step(1, 64, 0, 0, 0, 0);
    n_checks++;
    if (board_rdaddress !== 11'd2) begin n_fail++; $display("FAIL reset_scroll_cleared: got %0d want 2", board_rdaddress); end
    for (int i = 0; i < 5; i++) begin
      step(0, 9, 9, 0, 0, 0);
      n_checks++;
      if (color_valid !== m_vld || color !== m_color) begin
        n_fail++; $display("FAIL post_reset %0d: got v=%b %h want v=%b %h", i, color_valid, color, m_vld, m_color);
      end
    end
  endtask

`ifdef TILE_RENDER_PIPE_FLIP_EN
  task automatic test_flip();
    board_mem[80] = 7'b01_00011;
    step(1, 4, 70, 0, 0, 0);
    step(0, 9, 9, 0, 0, 0);
    step(0, 9, 9, 0, 0, 0);
    n_checks++;
    if (sprite_rdaddress !== 13'd829) begin n_fail++; $display("FAIL flip_sprite_addr: got %0d want 829", sprite_rdaddress); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 2048; i++) board_mem[i] = BDW'($urandom);
    for (int i = 0; i < 8192; i++) sprite_mem[i] = 6'($urandom);
    for (int i = 0; i < 64; i++) color_mem[i] = 24'($urandom);
    model_clear();
    test_reset();
    test_basic_pixel();
    test_scroll_update();
    test_scroll_err();
    test_border();
    test_back_to_back();
    test_reset_midstream();
`ifdef TILE_RENDER_PIPE_FLIP_EN
    test_flip();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
